uart_rx: RTL and testbench

- 8N1 UART receiver: the receive-side counterpart of the SDRAM test harness's serial transmit path.
- Deserialises the asynchronous `rxd` pin into bytes and hands them to the on-chip consumer through a one-entry valid/ready holding register.
- Reports framing and overrun errors.
- Sits between the board `UART_RX` pin and the test core's command/console logic. Runs on `sysclk`.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, widths and baud divisor helper
package uart_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // sysclk_frequency is in units of 100 kHz; result is truncated
    function automatic int calc_bit_clocks(input int sysclk_frequency, input int baud);
        return (sysclk_frequency * 100000) / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous input
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-entry valid/ready holding register
module uart_rx
    import uart_pkg::*;
#(
    parameter int sysclk_frequency = 1330,
    parameter int baud             = 115200
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  framing_error,
    output logic                  overrun,
    output logic                  busy
);

    localparam int BIT_CLOCKS  = calc_bit_clocks(sysclk_frequency, baud);
    localparam int HALF_CLOCKS = BIT_CLOCKS / 2;
    localparam int CW          = $clog2(BIT_CLOCKS);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CLOCKS - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CLOCKS - 1);

    logic                  rxs;
    rx_state_t             state, state_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [DATA_WIDTH-1:0] shift, shift_next;
    logic [2:0]            idx, idx_next;
    logic                  sample;
    logic                  deliver;
    logic                  frame_bad;
    logic                  load;

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset_in),
        .d     (rxd),
        .q     (rxs)
    );

    assign sample = (cnt == '0);
    assign busy   = (state != IDLE);
    // A good byte is accepted if the slot is empty or being emptied this same edge
    assign load   = deliver && (!rx_valid || rx_ready);

    always_comb begin
        state_next = state;
        cnt_next   = sample ? cnt : cnt - CW'(1);
        shift_next = shift;
        idx_next   = idx;
        deliver    = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    cnt_next   = HALF_LOAD;
                    state_next = START;
                end
            end
            START: begin
                if (sample) begin
                    if (rxs) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next   = BIT_LOAD;
                        idx_next   = 3'd0;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_next = {rxs, shift[DATA_WIDTH-1:1]};
                    cnt_next   = BIT_LOAD;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (sample) begin
                    if (rxs) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off while the line is in break so it cannot start a new frame
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state <= IDLE;
            cnt   <= '0;
            shift <= '0;
            idx   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            shift <= shift_next;
            idx   <= idx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= frame_bad;
            overrun       <= deliver && rx_valid && !rx_ready;
            if (load) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

    localparam int BC = 16;

    logic       clk = 1'b0;
    logic       reset_in = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    int         fe_count = 0;
    int         ov_count = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    always #5 clk = ~clk;

    uart_rx #(
        .sysclk_frequency(16),
        .baud            (100000)
    ) dut (
        .clk           (clk),
        .reset_in      (reset_in),
        .rxd           (rxd),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .framing_error (framing_error),
        .overrun       (overrun),
        .busy          (busy)
    );

    // Every handshake the DUT presents is matched against the next expected byte
    always @(negedge clk) begin
        if (!reset_in) begin
            if (framing_error) fe_count++;
            if (overrun) ov_count++;
            if (rx_valid && rx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected actual %02h required none", rx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (rx_data !== exp_b) begin
                        errors++;
                        $display("FAIL pop_data actual %02h required %02h", rx_data, exp_b);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) idle(1);
        check(name, exp_q.size(), 0);
    endtask

    // Drives one frame a cycle at a time; pulse_at raises rx_ready for one cycle,
    // abort_at applies a one-cycle reset and releases the line
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int pulse_at, input int abort_at);
        int k;
        for (int c = 0; c < 10 * BC; c++) begin
            if (abort_at >= 0 && c == abort_at) begin
                reset_in = 1'b1;
                rxd      = 1'b1;
                idle(1);
                reset_in = 1'b0;
                return;
            end
            k = c / BC;
            if (k == 0) rxd = 1'b0;
            else if (k == 9) rxd = stop_bit;
            else rxd = b[k-1];
            if (pulse_at >= 0 && c == pulse_at) rx_ready = 1'b1;
            if (pulse_at >= 0 && c == pulse_at + 1) rx_ready = 1'b0;
            idle(1);
        end
    endtask

    initial begin
        idle(3);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_framing_error", framing_error, 0);
        check("reset_overrun", overrun, 0);
        check("reset_busy", busy, 0);
        reset_in = 1'b0;
        idle(4);

        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA3);
        send_frame(8'h55, 1'b1, -1, -1);
        send_frame(8'hA3, 1'b1, -1, -1);
        wait_drain("b2b_drain");
        idle(5);
        check("b2b_framing_count", fe_count, 0);
        check("b2b_overrun_count", ov_count, 0);

        send_frame(8'h3C, 1'b0, -1, -1);
        idle(34);
        check("fe_busy_while_low", busy, 1);
        check("fe_count", fe_count, 1);
        rxd = 1'b1;
        idle(1);
        check("fe_busy_after_rise", busy, 1);
        idle(2);
        check("fe_busy_released", busy, 0);
        check("fe_no_valid", rx_valid, 0);

        rxd = 1'b0;
        idle(5);
        rxd = 1'b1;
        idle(20);
        check("glitch_busy", busy, 0);
        check("glitch_no_valid", rx_valid, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1, -1);
        wait_drain("glitch_then_81");
        check("glitch_framing_count", fe_count, 1);
        check("glitch_overrun_count", ov_count, 0);

        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        idle(3);
        check("ovr_valid", rx_valid, 1);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_count", ov_count, 1);
        rx_ready = 1'b1;
        idle(1);
        check("ovr_popped_valid", rx_valid, 0);
        check("ovr_queue_empty", exp_q.size(), 0);

        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, -1);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, 9 * BC + BC / 2 + 2, -1);
        idle(3);
        check("swap_valid", rx_valid, 1);
        check("swap_data", rx_data, 8'h22);
        check("swap_no_overrun", ov_count, 1);
        check("swap_one_pending", exp_q.size(), 1);
        rx_ready = 1'b1;
        wait_drain("swap_drain");

        send_frame(8'hA5, 1'b1, -1, 5 * BC + 8);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_framing_error", framing_error, 0);
        check("rst_overrun", overrun, 0);
        idle(5);
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b1, -1, -1);
        wait_drain("rst_then_f0");
        check("final_framing_count", fe_count, 1);
        check("final_overrun_count", ov_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
